// File: rtl/max_index_if.sv
// max_index_if: bundles the packed value bus and the registered arg-max result
//   Num   : N*W packed signed values, element k at [k*W +: W]
//   Index : IW-bit index of the largest element
//   master drives Num and observes Index; slave observes Num and drives Index
interface max_index_if #(
    parameter int N  = 10,
    parameter int W  = 26,
    parameter int IW = 4
);
    logic [N*W-1:0] Num;
    logic [IW-1:0]  Index;

    modport master (output Num, input Index);
    modport slave  (input Num, output Index);
endinterface

// File: rtl/max_index.sv
// max_index: registered arg-max over N packed signed values, lowest index wins ties
//   clk         : rising-edge clock
//   GlobalReset : asynchronous active-low reset, clears Index to 0
//   bus.Num     : N*W packed signed values (element 0 in the LSBs)
//   bus.Index   : registered index of the maximum element, always in 0..N-1
module max_index #(
    parameter int N  = 10,
    parameter int W  = 26,
    parameter int IW = 4
) (
    input  logic        clk,
    input  logic        GlobalReset,
    max_index_if.slave  bus
);
    localparam int P = 1 << $clog2(N);

    // Heap-ordered tournament tree: node 0 is the root, leaves sit at P-1+k.
    // A left child always covers lower indices than its right sibling.
    logic signed [W-1:0] node_val [2*P-1];
    logic [IW-1:0]       node_idx [2*P-1];
    logic [IW-1:0]       index_d;
    logic [IW-1:0]       index_q;

    genvar k;
    for (k = 0; k < P; k++) begin : g_leaf
        if (k < N) begin : g_in
            assign node_val[P-1+k] = bus.Num[k*W +: W];
        end else begin : g_pad
            // Padding leaves hold the minimum value and the highest indices,
            // so they lose every comparison, including ties.
            assign node_val[P-1+k] = {1'b1, {(W-1){1'b0}}};
        end
        assign node_idx[P-1+k] = IW'(k);
    end

    for (k = 0; k < P-1; k++) begin : g_node
        logic right_wins;
        // Strict compare: equality forwards the lower-index left operand.
        assign right_wins  = node_val[2*k+2] > node_val[2*k+1];
        assign node_val[k] = right_wins ? node_val[2*k+2] : node_val[2*k+1];
        assign node_idx[k] = right_wins ? node_idx[2*k+2] : node_idx[2*k+1];
    end

    always_comb index_d = node_idx[0];

    always_ff @(posedge clk or negedge GlobalReset)
        if (!GlobalReset) index_q <= '0;
        else              index_q <= index_d;

    assign bus.Index = index_q;
endmodule

// File: tb/tb_max_index.sv
// tb_max_index: randomized and directed checks of max_index against an arg-max model
module tb_max_index;
    localparam int N  = 10;
    localparam int W  = 26;
    localparam int IW = 4;

    logic clk = 0;
    logic GlobalReset = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic signed [W-1:0] v [N];

    max_index_if #(.N(N), .W(W), .IW(IW)) mif ();
    max_index #(.N(N), .W(W), .IW(IW)) dut (
        .clk(clk),
        .GlobalReset(GlobalReset),
        .bus(mif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) mif.Num[i*W +: W] = v[i];
    endtask

    function automatic int ref_argmax();
        int best = 0;
        for (int i = 1; i < N; i++) if (v[i] > v[best]) best = i;
        return best;
    endfunction

    task automatic step_check(input string tag, input int exp);
        @(posedge clk);
        #1;
        check(tag, int'(mif.Index), exp);
    endtask

    task automatic fill(input int val);
        for (int i = 0; i < N; i++) v[i] = W'(val);
    endtask

    initial begin
        for (int i = 0; i < N; i++) v[i] = W'($urandom);
        drive();
        #1 check("reset_immediate", int'(mif.Index), 0);
        repeat (3) step_check("reset_hold", 0);

        GlobalReset = 1;
        v[0] = -10; v[1] = -15; v[2] = -2; v[3] = -100; v[4] = -30;
        v[5] = -10000; v[6] = -200; v[7] = -301234; v[8] = -1; v[9] = -69;
        drive();
        #2 check("neg_before_edge", int'(mif.Index), 0);
        step_check("all_negative", 8);

        fill(0); v[3] = 26'sh1FFFFFF; v[7] = 26'sh2000000; drive();
        step_check("max_pos", 3);
        fill(-(1 << 25)); v[9] = -(1 << 25) + 1; drive();
        step_check("min_plus_one", 9);
        fill(-(1 << 25)); drive();
        step_check("all_min_tie", 0);
        fill(5); drive();
        step_check("tie_all_five", 0);
        fill(0); v[4] = 100; v[6] = 100; drive();
        step_check("tie_4_6", 4);

        fill(0); v[0] = 1; drive();
        step_check("stream_0", 0);
        fill(0); v[9] = 1; drive();
        step_check("stream_9", 9);
        fill(0); v[5] = 1; drive();
        step_check("stream_5", 5);

        fill(0); v[9] = 1; drive();
        step_check("pre_reset_9", 9);
        #2 GlobalReset = 0;
        #1 check("async_reset", int'(mif.Index), 0);
        fill(0); v[7] = 3; drive();
        repeat (2) step_check("reset_mid_hold", 0);
        GlobalReset = 1;
        step_check("release", 7);

        for (int c = 0; c < 300; c++) begin
            int mode = $urandom_range(0, 3);
            for (int i = 0; i < N; i++) begin
                case (mode)
                    0: v[i] = W'($urandom);
                    1: v[i] = W'($urandom_range(0, 6)) - 3;
                    2: v[i] = $urandom_range(0, 1) ? 26'sh1FFFFFF : 26'sh2000000;
                    default: v[i] = W'($urandom_range(0, 2)) - (1 << 25);
                endcase
            end
            drive();
            if (c % 60 == 59) begin
                GlobalReset = 0;
                #1 check("rand_async_reset", int'(mif.Index), 0);
                step_check("rand_reset_hold", 0);
                GlobalReset = 1;
            end
            step_check("random", ref_argmax());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
